// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// parity helper that the receiver and the planned transmitter both use.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity bit that makes the total number of ones even (odd = 0) or odd
  // (odd = 1). Narrower words are zero-extended to 9 bits by the caller.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on
// rd_data whenever the FIFO is non-empty and reads as zero when empty. A push
// into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push and pop together keep count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written since rd_data is
  // forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing feeding a FWFT FIFO of
// {frame_err, parity_err, data} entries.
//
// Handshake: the head entry is valid whenever empty=0; the consumer takes it
// by asserting rd_en for one MCLK cycle (rd_en while empty is ignored). The
// receiver side has no back-pressure: RX_Done marks the cycle in which an
// entry is offered to the FIFO, and a full FIFO drops it (setting overrun)
// unless the consumer pops in that same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          MCLK,
  input  logic                          RST,
  input  logic                          tick_clk,
  input  logic                          RX,
  input  logic                          rd_en,
  output logic [DBIT-1:0]               DATAOUT,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic                          RX_Done,
  output logic [2:0]                    state_dbg
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_DATA_LAST = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_STOP_LAST = NW'(STOP_BITS - 1);

  logic            rx_meta, rx_s;
  rx_state_e       state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] data, data_n;
  logic            perr, perr_n;
  logic            ferr, ferr_n;
  logic            done_n;
  logic            push_q;
  logic [DBIT+1:0] push_word_q;
  logic [DBIT+1:0] head;

  // Two-flop synchroniser for the asynchronous line, idle-high after reset.
  always_ff @(posedge MCLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state <= ST_IDLE;
      s     <= '0;
      n     <= '0;
      data  <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      data  <= data_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
    end
  end

  // Next-state logic: counters advance only on tick_clk; every bit after the
  // start bit is sampled at s=OVERSAMPLE-1, i.e. at its centre because the
  // start bit was validated at its own centre.
  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    data_n  = data;
    perr_n  = perr;
    ferr_n  = ferr;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_n = ST_START;
          s_n     = '0;
        end
      end
      ST_START: begin
        if (tick_clk) begin
          if (s == S_MID) begin
            s_n = '0;
            n_n = '0;
            if (!rx_s) begin
              state_n = ST_DATA;
              perr_n  = 1'b0;
              ferr_n  = 1'b0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick_clk) begin
          if (s == S_LAST) begin
            s_n    = '0;
            data_n = {rx_s, data[DBIT-1:1]};
            if (n == N_DATA_LAST) begin
              n_n     = '0;
              state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick_clk) begin
          if (s == S_LAST) begin
            s_n     = '0;
            n_n     = '0;
            perr_n  = (rx_s != parity_bit(9'(data), (PARITY_ODD != 0)));
            state_n = ST_STOP;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick_clk) begin
          if (s == S_LAST) begin
            s_n    = '0;
            ferr_n = ferr | ~rx_s;
            if (n == N_STOP_LAST) begin
              n_n     = '0;
              done_n  = 1'b1;
              state_n = ST_IDLE;
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        s_n     = '0;
        n_n     = '0;
      end
    endcase
  end

  // Register the completed frame so RX_Done and the FIFO push share one cycle.
  always_ff @(posedge MCLK) begin
    if (RST) begin
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else begin
      push_q <= done_n;
      if (done_n) push_word_q <= {ferr_n, perr_n, data_n};
    end
  end

  // Sticky overrun: a push into a full FIFO with no simultaneous pop is lost.
  always_ff @(posedge MCLK) begin
    if (RST) begin
      overrun <= 1'b0;
    end else if (push_q && full && !rd_en) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DBIT + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (MCLK),
    .rst     (RST),
    .wr_en   (push_q),
    .wr_data (push_word_q),
    .rd_en   (rd_en),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign {frame_err, parity_err, DATAOUT} = head;
  assign RX_Done   = push_q;
  assign state_dbg = state;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receive channel replacing the fixed 8N1 receiver plus single-byte holding buffer. It oversamples the serial line on a shared baud tick, frames words of configurable width with optional parity and one or two stop bits, and queues each received word with its error flags in a first-word-fall-through FIFO. It sits between the pin-level RX input and the host-side consumer, next to the existing baud-tick generator.

## Interface
- DBIT, 8: data bits per frame, 5..9, LSB first on the line.
- OVERSAMPLE, 16: tick_clk strobes per bit period, even, ≥8.
- STOP_BITS, 1: 1 or 2.
- PARITY_EN, 0: 1 = parity bit follows data.
- PARITY_ODD, 0: 1 = odd parity, 0 = even (ignored if PARITY_EN=0).
- FIFO_DEPTH, 16: entries, power of two, ≥2.

Ports:
- MCLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- tick_clk  in  1  one-MCLK-cycle strobe at baud×OVERSAMPLE.
- RX  in  1  asynchronous serial input, idle high.
- rd_en  in  1  pop head entry; ignored when empty.
- DATAOUT  out  DBIT  head data word; 0 when empty.
- parity_err  out  1  parity error flag of head entry; 0 when empty.
- frame_err  out  1  stop-bit error flag of head entry; 0 when empty.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  clog2(FIFO_DEPTH)+1  entries held.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- overrun_clr  in  1  clears overrun (set wins if same cycle).
- RX_Done  out  1  one-cycle pulse per completed frame, dropped or not.

## Operation
- RX passes through a 2-FF synchroniser, reset to 1. All decisions use the synchronised value rx_s.
- Receiver FSM states: IDLE, START, DATA, PARITY, STOP. It uses a tick counter s (0..OVERSAMPLE-1) and a bit counter n.
- IDLE: when rx_s=0, go to START with s=0.
- START: on each tick, s++. When s=OVERSAMPLE/2-1, sample rx_s. If it is 0, go to DATA with s=0, n=0. If it is 1, the low pulse was a glitch: go to IDLE and push nothing.
- DATA: on the tick with s=OVERSAMPLE-1, shift rx_s into the MSB of the DBIT shift register (right shift) and set s=0. After bit n=DBIT-1, go to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY: sample at the same point. parity_err_int = (XOR of data ^ sampled bit) != PARITY_ODD.
- STOP: sample each stop bit at its mid point. frame_err_int = 1 if any stop sample is 0. After the last stop sample:
  - pulse RX_Done;
  - push {frame_err_int, parity_err_int, data};
  - return to IDLE in the same cycle.
- Push with FIFO full: the entry is discarded and overrun is set. Exception: rd_en is asserted in the same cycle, in which case both the push and the pop happen and count is unchanged.
- Simultaneous push and pop when not empty: count is unchanged. Pop when empty is a no-op.
- Between ticks, the FSM and counters hold.
- Reset mid-frame: FSM goes to IDLE, s=n=0, FIFO pointers and count go to 0, overrun=0. The partial frame is lost.
- Reset values: DATAOUT=0, parity_err=0, frame_err=0, empty=1, full=0, count=0, overrun=0, RX_Done=0.

## Timing
- From the RX edge, the synchroniser adds 2 MCLK of latency.
- The frame is pushed on the MCLK edge following the last stop-bit sample tick. RX_Done is high for that one cycle.
- empty deasserts, count increments and DATAOUT/flags show the new head on the cycle after the push (FWFT, registered pointers).
- rd_en high at edge k: the next entry (or zeros if none) appears at k+1.
- A new start bit is accepted in the cycle after the STOP→IDLE transition. Back-to-back frames with zero extra idle are received.
- count, empty, full and overrun are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package uart_pkg holds:
  - the FSM state encoding (IDLE/START/DATA/PARITY/STOP);
  - the parity mode constants;
  - a parity-compute function shared with the planned transmitter.
- Natural sub-module: sync_fifo, parametrised in WIDTH (DBIT+2) and DEPTH. It provides FWFT, count/full/empty, and the simultaneous push/pop-when-full rule.
- The receiver FSM and synchroniser stay in uart_rx_fifo.

## Test plan
- Reset and idle: RST for 3 cycles with RX=1 → all outputs at reset values. No RX_Done for 2000 cycles.
- Single 8N1 frame 0xA5: tick every 4 MCLK, OVERSAMPLE=16 → one RX_Done pulse, then DATAOUT=0xA5, count=1, parity_err=0, frame_err=0. rd_en → empty=1, DATAOUT=0.
- Glitch and stop error:
  - a low pulse of OVERSAMPLE/4 ticks → nothing pushed;
  - frame 0x3C with stop bit driven 0 → entry 0x3C, frame_err=1.
- Parity: DBIT=7, PARITY_EN=1, PARITY_ODD=0.
  - send 0x41 with correct parity 0 → parity_err=0;
  - send 0x41 with parity bit forced 1 → parity_err=1.
- Overrun: FIFO_DEPTH=4, send 5 frames (0x01..0x05) with no reads → full=1, count=4, overrun=1, entries 0x01..0x04 pop in order. Repeat with rd_en coinciding with the 5th push → overrun=0, 0x05 retained.
- Reset mid-frame: assert RST during DATA bit 3 of 0x55 → count=0, FSM in IDLE. The next frame 0x12 is received correctly.
